// File: rtl/sysclk_region_pkg.sv
// Shared encodings for the SNES sysclk region detector: region codes, FSM states,
// the "no measurement" sentinel and the min/max statistics payload.
package sysclk_region_pkg;

  localparam int unsigned FREQ_W = 32;
  localparam int unsigned RUN_W  = 4;

  localparam logic [FREQ_W-1:0] FREQ_INVALID = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REGION_NONE = 2'b00,
    REGION_NTSC = 2'b01,
    REGION_PAL  = 2'b10,
    REGION_UNK  = 2'b11
  } region_e;

  typedef enum logic [1:0] {
    ST_NOCLK = 2'd0,
    ST_ACQ   = 2'd1,
    ST_LOCK  = 2'd2
  } state_e;

  typedef struct packed {
    logic [FREQ_W-1:0] freq_min;
    logic [FREQ_W-1:0] freq_max;
  } freq_stats_t;

endpackage

// File: rtl/sysclk_region_detect_if.sv
// Measurement input and region status bundle between the frequency counter,
// the region detector and the MCU register file.
interface sysclk_region_detect_if;
  import sysclk_region_pkg::*;

  logic [FREQ_W-1:0] freq_in;
  logic              freq_stb;
  logic              stat_clr;
  logic [1:0]        region;
  logic              locked;
  logic              region_chg;
  logic [FREQ_W-1:0] freq_lock;
  logic [FREQ_W-1:0] freq_min;
  logic [FREQ_W-1:0] freq_max;

  modport master (
    output freq_in, freq_stb, stat_clr,
    input  region, locked, region_chg, freq_lock, freq_min, freq_max
  );

  modport slave (
    input  freq_in, freq_stb, stat_clr,
    output region, locked, region_chg, freq_lock, freq_min, freq_max
  );

endinterface

// File: rtl/sysclk_classify.sv
// Combinational range compare of one frequency measurement against the
// no-clock / NTSC / PAL windows; anything else is reported as unknown.
module sysclk_classify
  import sysclk_region_pkg::*;
#(
  parameter int unsigned NONE_MAX = 1000000,
  parameter int unsigned NTSC_MIN = 21370000,
  parameter int unsigned NTSC_MAX = 21590000,
  parameter int unsigned PAL_MIN  = 21175000,
  parameter int unsigned PAL_MAX  = 21369999
) (
  input  logic [FREQ_W-1:0] freq_i,
  output region_e           class_c_o
);

  localparam logic [FREQ_W-1:0] NONE_MAX_C = FREQ_W'(NONE_MAX);
  localparam logic [FREQ_W-1:0] NTSC_MIN_C = FREQ_W'(NTSC_MIN);
  localparam logic [FREQ_W-1:0] NTSC_MAX_C = FREQ_W'(NTSC_MAX);
  localparam logic [FREQ_W-1:0] PAL_MIN_C  = FREQ_W'(PAL_MIN);
  localparam logic [FREQ_W-1:0] PAL_MAX_C  = FREQ_W'(PAL_MAX);

  // No-clock test has priority so a tiny count never lands in a console window.
  always_comb begin
    class_c_o = REGION_UNK;
    if (freq_i <= NONE_MAX_C) begin
      class_c_o = REGION_NONE;
    end else if ((freq_i >= NTSC_MIN_C) && (freq_i <= NTSC_MAX_C)) begin
      class_c_o = REGION_NTSC;
    end else if ((freq_i >= PAL_MIN_C) && (freq_i <= PAL_MAX_C)) begin
      class_c_o = REGION_PAL;
    end
  end

endmodule

// File: rtl/sysclk_region_detect.sv
// Debounced console-region detector: classifies each sysclk measurement, locks
// after a run of identical classes, drops to no-clock on a measurement watchdog.
module sysclk_region_detect
  import sysclk_region_pkg::*;
#(
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 200000000,
  parameter int unsigned NONE_MAX       = 1000000,
  parameter int unsigned NTSC_MIN       = 21370000,
  parameter int unsigned NTSC_MAX       = 21590000,
  parameter int unsigned PAL_MIN        = 21175000,
  parameter int unsigned PAL_MAX        = 21369999
) (
  input  logic                   clk,
  input  logic                   rst,
  sysclk_region_detect_if.slave  bus
);

  localparam logic [RUN_W-1:0]  STABLE_C  = RUN_W'(STABLE_COUNT);
  localparam logic [FREQ_W-1:0] TIMEOUT_C = FREQ_W'(TIMEOUT_CYCLES);
  localparam logic [RUN_W-1:0]  RUN_ONE   = RUN_W'(1);

  region_e           cls_c;
  logic              accept_c;
  logic              wd_expire_c;
  logic [FREQ_W-1:0] wd_inc_c;
  logic [RUN_W-1:0]  run_inc_c;

  state_e            state_q,  state_d;
  region_e           cand_q,   cand_d;
  region_e           region_q, region_d;
  logic [RUN_W-1:0]  run_q,    run_d;
  logic [FREQ_W-1:0] wd_q,     wd_d;
  logic              locked_q, locked_d;
  logic              chg_q,    chg_d;
  logic [FREQ_W-1:0] flock_q,  flock_d;
  freq_stats_t       stats_q,  stats_d;

  sysclk_classify #(
    .NONE_MAX (NONE_MAX),
    .NTSC_MIN (NTSC_MIN),
    .NTSC_MAX (NTSC_MAX),
    .PAL_MIN  (PAL_MIN),
    .PAL_MAX  (PAL_MAX)
  ) u_classify (
    .freq_i    (bus.freq_in),
    .class_c_o (cls_c)
  );

  // Sentinel strobes carry no measurement and must not feed the watchdog.
  assign accept_c    = bus.freq_stb && (bus.freq_in != FREQ_INVALID);
  assign wd_inc_c    = (wd_q == FREQ_INVALID) ? wd_q : (wd_q + FREQ_W'(1));
  assign wd_expire_c = !accept_c && (wd_inc_c >= TIMEOUT_C);
  assign run_inc_c   = (run_q >= STABLE_C) ? run_q : (run_q + RUN_ONE);

  // Next-state: lock FSM, run counter, watchdog and statistics.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    region_d = region_q;
    run_d    = run_q;
    wd_d     = accept_c ? '0 : wd_inc_c;
    locked_d = locked_q;
    chg_d    = 1'b0;
    flock_d  = flock_q;
    stats_d  = stats_q;

    if (bus.stat_clr) begin
      stats_d = '{freq_min: FREQ_INVALID, freq_max: '0};
    end

    if (accept_c) begin
      if ((state_q == ST_LOCK) && (cls_c == cand_q)) begin
        if (bus.freq_in < stats_d.freq_min) stats_d.freq_min = bus.freq_in;
        if (bus.freq_in > stats_d.freq_max) stats_d.freq_max = bus.freq_in;
      end else begin
        // A run only continues while acquiring; any other entry restarts it.
        cand_d = cls_c;
        run_d  = ((state_q == ST_ACQ) && (cls_c == cand_q)) ? run_inc_c : RUN_ONE;
        if (run_d >= STABLE_C) begin
          state_d  = ST_LOCK;
          region_d = cls_c;
          locked_d = 1'b1;
          chg_d    = (cls_c != region_q);
          flock_d  = bus.freq_in;
          stats_d  = '{freq_min: bus.freq_in, freq_max: bus.freq_in};
        end else begin
          state_d  = ST_ACQ;
          locked_d = 1'b0;
        end
      end
    end else if (wd_expire_c) begin
      state_d  = ST_NOCLK;
      region_d = REGION_NONE;
      locked_d = 1'b0;
      run_d    = '0;
      chg_d    = (region_q != REGION_NONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NOCLK;
      cand_q   <= REGION_NONE;
      region_q <= REGION_NONE;
      run_q    <= '0;
      wd_q     <= '0;
      locked_q <= 1'b0;
      chg_q    <= 1'b0;
      flock_q  <= '0;
      stats_q  <= '{freq_min: FREQ_INVALID, freq_max: '0};
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      region_q <= region_d;
      run_q    <= run_d;
      wd_q     <= wd_d;
      locked_q <= locked_d;
      chg_q    <= chg_d;
      flock_q  <= flock_d;
      stats_q  <= stats_d;
    end
  end

  assign bus.region     = region_q;
  assign bus.locked     = locked_q;
  assign bus.region_chg = chg_q;
  assign bus.freq_lock  = flock_q;
  assign bus.freq_min   = stats_q.freq_min;
  assign bus.freq_max   = stats_q.freq_max;

endmodule
